// File: rtl/reorder_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer_pkg
// Description : Shared constants and types for the reorder buffer and the
//               blocks that exchange ROB tags with it (RS, LSB, RF).
//               Entry type encodings:
//                  ROB_T_REG  = 0 : register-writing instruction
//                  ROB_T_BR   = 1 : conditional branch
//                  ROB_T_ST   = 2 : store
//                  ROB_T_JALR = 3 : indirect jump, writes rd = pc+4
//               Tag convention for RS/RF: a tag carries one extra MSB. When
//               that bit is set the operand has no pending producer;
//               NO_ROB_TAG_EXT is the canonical "no tag" value.
// Revision    : 1.0 - initial release
// ============================================================================
package reorder_buffer_pkg;

   localparam int ROB_DEPTH_DEF = 16;
   localparam int IDX_W_DEF     = 4;
   localparam int XLEN_DEF      = 32;

   typedef enum logic [1:0] {
      ROB_T_REG  = 2'd0,
      ROB_T_BR   = 2'd1,
      ROB_T_ST   = 2'd2,
      ROB_T_JALR = 2'd3
   } rob_type_e;

   localparam logic [IDX_W_DEF-1:0] NO_ROB_TAG     = {IDX_W_DEF{1'b1}};
   localparam logic [IDX_W_DEF:0]   NO_ROB_TAG_EXT = {1'b1, NO_ROB_TAG};

   // A JALR always redirects; a branch redirects only when its resolved
   // direction disagrees with the prediction made at fetch.
   function automatic logic is_mispredict(input rob_type_e t,
                                          input logic      pred,
                                          input logic      taken);
      return (t == ROB_T_JALR) || ((t == ROB_T_BR) && (taken != pred));
   endfunction

endpackage
`default_nettype wire

// File: rtl/reorder_buffer_ptr.sv
`default_nettype none
// ============================================================================
// Module      : rob_ptr
// Description : Wrap-around circular-buffer pointer. Increments by one and
//               wraps DEPTH-1 -> 0; clr returns it to 0 and wins over inc.
// Ports       : clk, rst (sync, active-high), inc, clr, ptr[IDX_W-1:0]
// Revision    : 1.0 - initial release
// ============================================================================
module rob_ptr #(
   parameter int DEPTH = 16,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [IDX_W-1:0] ptr
);

   localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);
   localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= (ptr == LAST) ? '0 : ptr + ONE;
      end
   end

endmodule
`default_nettype wire

// File: rtl/reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : reorder_buffer
// Description : In-order retirement queue for the Tomasulo core. Dispatch
//               allocates at the tail, the RS/LSB result buses complete
//               entries out of order, and the head retires in program order.
//               A mispredicted branch or any JALR flushes the whole buffer.
// Ports       : clk, rst, rdy (global enable)
//               issue_*  : dispatch handshake, issue_tag = allocated index
//               qj_/qk_  : operand lookup by tag
//               alu_wb_* / lsb_wb_* : result buses
//               commit_* : registered retire pulse to RF / LSB
//               flush, flush_pc : registered redirect
//               train_*  : registered predictor update on branch commit
// Config      : ROB_WB_BYPASS_EN - lookups also see the current-cycle
//               result buses (LSB wins when both hit the same tag).
// Revision    : 1.0 - initial release
// ============================================================================
module reorder_buffer
   import reorder_buffer_pkg::*;
#(
   parameter int ROB_DEPTH = ROB_DEPTH_DEF,
   parameter int IDX_W     = IDX_W_DEF,
   parameter int XLEN      = XLEN_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   // dispatch
   input  logic             issue_valid,
   output logic             issue_ready,
   input  logic [1:0]       issue_type,
   input  logic [4:0]       issue_rd,
   input  logic [XLEN-1:0]  issue_pc,
   input  logic             issue_pred,
   output logic [IDX_W-1:0] issue_tag,
   // operand lookup
   input  logic [IDX_W-1:0] qj_tag,
   output logic             qj_rdy,
   output logic [XLEN-1:0]  qj_val,
   input  logic [IDX_W-1:0] qk_tag,
   output logic             qk_rdy,
   output logic [XLEN-1:0]  qk_val,
   // result buses
   input  logic             alu_wb_valid,
   input  logic [IDX_W-1:0] alu_wb_tag,
   input  logic [XLEN-1:0]  alu_wb_val,
   input  logic             alu_wb_taken,
   input  logic [XLEN-1:0]  alu_wb_target,
   input  logic             lsb_wb_valid,
   input  logic [IDX_W-1:0] lsb_wb_tag,
   input  logic [XLEN-1:0]  lsb_wb_val,
   // commit
   output logic             commit_valid,
   output logic [4:0]       commit_rd,
   output logic [XLEN-1:0]  commit_val,
   output logic [IDX_W-1:0] commit_tag,
   output logic             commit_store,
   output logic             flush,
   output logic [XLEN-1:0]  flush_pc,
   output logic             train_valid,
   output logic [XLEN-1:0]  train_pc,
   output logic             train_taken
);

   localparam logic [IDX_W:0]  FULL_COUNT = (IDX_W + 1)'(ROB_DEPTH);
   localparam logic [IDX_W:0]  CNT_ONE    = (IDX_W + 1)'(1);
   localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

   // flat per-field entry storage
   logic [ROB_DEPTH-1:0] busy;
   logic [ROB_DEPTH-1:0] ready;
   logic [ROB_DEPTH-1:0] ent_pred;
   logic [ROB_DEPTH-1:0] ent_taken;
   rob_type_e            ent_type   [ROB_DEPTH];
   logic [4:0]           ent_rd     [ROB_DEPTH];
   logic [XLEN-1:0]      ent_pc     [ROB_DEPTH];
   logic [XLEN-1:0]      ent_val    [ROB_DEPTH];
   logic [XLEN-1:0]      ent_target [ROB_DEPTH];

   logic [IDX_W-1:0] head;
   logic [IDX_W-1:0] tail;
   logic [IDX_W:0]   count;

   logic            full;
   logic            issue_fire;
   logic            commit_fire;
   logic            flush_fire;
   logic            wb_enable;
   logic            alu_hit;
   logic            lsb_hit;
   rob_type_e       head_type;
   logic            head_mispred;
   logic [XLEN-1:0] head_pc4;

   // flush is high exactly in the cycle after a redirecting commit; the
   // buffer is already empty then, and anything still arriving belongs to
   // squashed instructions.
   assign full        = (count == FULL_COUNT);
   assign issue_ready = !full && !flush;
   assign issue_tag   = tail;
   assign issue_fire  = issue_valid && issue_ready && rdy;
   assign commit_fire = rdy && !flush && (count != '0) && ready[head];

   assign head_type    = ent_type[head];
   assign head_mispred = is_mispredict(head_type, ent_pred[head], ent_taken[head]);
   assign head_pc4     = ent_pc[head] + PC_STEP;
   assign flush_fire   = commit_fire && head_mispred;

   assign wb_enable = rdy && !flush;
   assign alu_hit   = wb_enable && alu_wb_valid && busy[alu_wb_tag];
   assign lsb_hit   = wb_enable && lsb_wb_valid && busy[lsb_wb_tag];

   rob_ptr #(.DEPTH(ROB_DEPTH), .IDX_W(IDX_W)) u_head_ptr (
      .clk (clk),
      .rst (rst),
      .inc (commit_fire),
      .clr (flush_fire),
      .ptr (head)
   );

   rob_ptr #(.DEPTH(ROB_DEPTH), .IDX_W(IDX_W)) u_tail_ptr (
      .clk (clk),
      .rst (rst),
      .inc (issue_fire),
      .clr (flush_fire),
      .ptr (tail)
   );

   // Status bits. A redirecting commit empties the buffer at the same edge
   // it raises flush, so the redirect cycle already sees an empty ROB.
   always_ff @(posedge clk) begin
      if (rst || flush_fire) begin
         busy  <= '0;
         ready <= '0;
      end else begin
         if (alu_hit) ready[alu_wb_tag] <= 1'b1;
         if (lsb_hit) ready[lsb_wb_tag] <= 1'b1;
         if (commit_fire) begin
            busy[head]  <= 1'b0;
            ready[head] <= 1'b0;
         end
         // tail never equals head while issue is allowed, except when empty
         if (issue_fire) begin
            busy[tail]  <= 1'b1;
            ready[tail] <= 1'b0;
         end
      end
   end

   // Payload fields need no reset: they are only read through busy/ready.
   always_ff @(posedge clk) begin
      if (alu_hit) begin
         ent_val[alu_wb_tag]    <= alu_wb_val;
         ent_taken[alu_wb_tag]  <= alu_wb_taken;
         ent_target[alu_wb_tag] <= alu_wb_target;
      end
      if (lsb_hit) begin
         ent_val[lsb_wb_tag] <= lsb_wb_val;
      end
      if (issue_fire) begin
         ent_type[tail] <= rob_type_e'(issue_type);
         ent_rd[tail]   <= issue_rd;
         ent_pc[tail]   <= issue_pc;
         ent_pred[tail] <= issue_pred;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush_fire) begin
         count <= '0;
      end else begin
         case ({issue_fire, commit_fire})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         commit_valid <= 1'b0;
         commit_rd    <= '0;
         commit_val   <= '0;
         commit_tag   <= '0;
         commit_store <= 1'b0;
         flush        <= 1'b0;
         flush_pc     <= '0;
         train_valid  <= 1'b0;
         train_pc     <= '0;
         train_taken  <= 1'b0;
      end else begin
         commit_valid <= 1'b0;
         commit_store <= 1'b0;
         flush        <= 1'b0;
         train_valid  <= 1'b0;
         if (commit_fire) begin
            commit_valid <= 1'b1;
            commit_tag   <= head;
            flush        <= head_mispred;
            case (head_type)
               ROB_T_REG: begin
                  commit_rd  <= ent_rd[head];
                  commit_val <= ent_val[head];
               end
               ROB_T_ST: begin
                  commit_rd    <= '0;
                  commit_val   <= ent_val[head];
                  commit_store <= 1'b1;
               end
               ROB_T_BR: begin
                  commit_rd   <= '0;
                  commit_val  <= ent_val[head];
                  train_valid <= 1'b1;
                  train_pc    <= ent_pc[head];
                  train_taken <= ent_taken[head];
                  flush_pc    <= ent_taken[head] ? ent_target[head] : head_pc4;
               end
               ROB_T_JALR: begin
                  commit_rd  <= ent_rd[head];
                  commit_val <= head_pc4;
                  flush_pc   <= ent_target[head];
               end
            endcase
         end
      end
   end

   // Operand lookup; only a completed, live entry returns a value.
   always_comb begin
      qj_rdy = busy[qj_tag] && ready[qj_tag];
      qj_val = qj_rdy ? ent_val[qj_tag] : '0;
      qk_rdy = busy[qk_tag] && ready[qk_tag];
      qk_val = qk_rdy ? ent_val[qk_tag] : '0;
`ifdef ROB_WB_BYPASS_EN
      // later assignments win, giving the LSB bus priority
      if (alu_hit && (alu_wb_tag == qj_tag)) begin
         qj_rdy = 1'b1;
         qj_val = alu_wb_val;
      end
      if (lsb_hit && (lsb_wb_tag == qj_tag)) begin
         qj_rdy = 1'b1;
         qj_val = lsb_wb_val;
      end
      if (alu_hit && (alu_wb_tag == qk_tag)) begin
         qk_rdy = 1'b1;
         qk_val = alu_wb_val;
      end
      if (lsb_hit && (lsb_wb_tag == qk_tag)) begin
         qk_rdy = 1'b1;
         qk_val = lsb_wb_val;
      end
`endif
   end

   wb_tags_distinct: assert property (@(posedge clk) disable iff (rst)
      !(alu_wb_valid && lsb_wb_valid && (alu_wb_tag == lsb_wb_tag)));

endmodule
`default_nettype wire

// File: tb/tb_reorder_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reorder_buffer
// Description : Self-checking bench for reorder_buffer. A table of single
//               instruction lifecycles (issue, writeback, commit) plus
//               hand-written sequences for fill, out-of-order completion,
//               pointer wrap, lookup timing and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reorder_buffer;
   import reorder_buffer_pkg::*;

   localparam int IDX_W = 4;
   localparam int XLEN  = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic             rdy;
   logic             issue_valid;
   logic             issue_ready;
   logic [1:0]       issue_type;
   logic [4:0]       issue_rd;
   logic [XLEN-1:0]  issue_pc;
   logic             issue_pred;
   logic [IDX_W-1:0] issue_tag;
   logic [IDX_W-1:0] qj_tag;
   logic             qj_rdy;
   logic [XLEN-1:0]  qj_val;
   logic [IDX_W-1:0] qk_tag;
   logic             qk_rdy;
   logic [XLEN-1:0]  qk_val;
   logic             alu_wb_valid;
   logic [IDX_W-1:0] alu_wb_tag;
   logic [XLEN-1:0]  alu_wb_val;
   logic             alu_wb_taken;
   logic [XLEN-1:0]  alu_wb_target;
   logic             lsb_wb_valid;
   logic [IDX_W-1:0] lsb_wb_tag;
   logic [XLEN-1:0]  lsb_wb_val;
   logic             commit_valid;
   logic [4:0]       commit_rd;
   logic [XLEN-1:0]  commit_val;
   logic [IDX_W-1:0] commit_tag;
   logic             commit_store;
   logic             flush;
   logic [XLEN-1:0]  flush_pc;
   logic             train_valid;
   logic [XLEN-1:0]  train_pc;
   logic             train_taken;

   reorder_buffer dut (
      .clk           (clk),
      .rst           (rst),
      .rdy           (rdy),
      .issue_valid   (issue_valid),
      .issue_ready   (issue_ready),
      .issue_type    (issue_type),
      .issue_rd      (issue_rd),
      .issue_pc      (issue_pc),
      .issue_pred    (issue_pred),
      .issue_tag     (issue_tag),
      .qj_tag        (qj_tag),
      .qj_rdy        (qj_rdy),
      .qj_val        (qj_val),
      .qk_tag        (qk_tag),
      .qk_rdy        (qk_rdy),
      .qk_val        (qk_val),
      .alu_wb_valid  (alu_wb_valid),
      .alu_wb_tag    (alu_wb_tag),
      .alu_wb_val    (alu_wb_val),
      .alu_wb_taken  (alu_wb_taken),
      .alu_wb_target (alu_wb_target),
      .lsb_wb_valid  (lsb_wb_valid),
      .lsb_wb_tag    (lsb_wb_tag),
      .lsb_wb_val    (lsb_wb_val),
      .commit_valid  (commit_valid),
      .commit_rd     (commit_rd),
      .commit_val    (commit_val),
      .commit_tag    (commit_tag),
      .commit_store  (commit_store),
      .flush         (flush),
      .flush_pc      (flush_pc),
      .train_valid   (train_valid),
      .train_pc      (train_pc),
      .train_taken   (train_taken)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      issue_valid   = 1'b0;
      issue_type    = 2'd0;
      issue_rd      = '0;
      issue_pc      = '0;
      issue_pred    = 1'b0;
      qj_tag        = '0;
      qk_tag        = '0;
      alu_wb_valid  = 1'b0;
      alu_wb_tag    = '0;
      alu_wb_val    = '0;
      alu_wb_taken  = 1'b0;
      alu_wb_target = '0;
      lsb_wb_valid  = 1'b0;
      lsb_wb_tag    = '0;
      lsb_wb_val    = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      rdy = 1'b1;
      idle_inputs();
      step();
      step();
      rst = 1'b0;
      #1;
   endtask

   task automatic alu_wb(input logic [IDX_W-1:0] tag, input logic [31:0] val,
                         input logic taken, input logic [31:0] target);
      alu_wb_valid  = 1'b1;
      alu_wb_tag    = tag;
      alu_wb_val    = val;
      alu_wb_taken  = taken;
      alu_wb_target = target;
   endtask

   typedef struct {
      logic [1:0]  typ;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic        pred;
      logic        use_lsb;
      logic        taken;
      logic [31:0] target;
      logic [31:0] val;
      logic [4:0]  e_rd;
      logic [31:0] e_val;
      logic        chk_val;
      logic        e_store;
      logic        e_flush;
      logic [31:0] e_flush_pc;
      logic        e_train;
      logic        e_train_taken;
   } vec_t;

   vec_t vecs[8];

   initial begin
      logic [IDX_W-1:0] exp_tag;

      //        typ        rd  pc      pr lsb tk target    val       e_rd e_val     cv st fl e_fpc     tr tt
      vecs[0] = '{ROB_T_REG,  5, 32'h40,  0, 0, 0, 32'h0,    32'h1234, 5,  32'h1234, 1, 0, 0, 32'h0,    0, 0};
      vecs[1] = '{ROB_T_ST,   7, 32'h44,  0, 1, 0, 32'h0,    32'h99,   0,  32'h0,    0, 1, 0, 32'h0,    0, 0};
      vecs[2] = '{ROB_T_BR,   0, 32'h100, 0, 0, 1, 32'h180,  32'h0,    0,  32'h0,    0, 0, 1, 32'h180,  1, 1};
      vecs[3] = '{ROB_T_BR,   0, 32'h200, 1, 0, 1, 32'h280,  32'h0,    0,  32'h0,    0, 0, 0, 32'h0,    1, 1};
      vecs[4] = '{ROB_T_BR,   0, 32'h200, 1, 0, 0, 32'h280,  32'h0,    0,  32'h0,    0, 0, 1, 32'h204,  1, 0};
      vecs[5] = '{ROB_T_BR,   0, 32'h300, 0, 0, 0, 32'h380,  32'h0,    0,  32'h0,    0, 0, 0, 32'h0,    1, 0};
      vecs[6] = '{ROB_T_JALR, 1, 32'h400, 0, 0, 0, 32'h1000, 32'h55,   1,  32'h404,  1, 0, 1, 32'h1000, 0, 0};
      vecs[7] = '{ROB_T_REG, 31, 32'h500, 0, 1, 0, 32'h0,    32'hDEAD, 31, 32'hDEAD, 1, 0, 0, 32'h0,    0, 0};

      // ---------------- reset state ----------------
      do_reset();
      check("rst_issue_ready",  issue_ready,  1);
      check("rst_issue_tag",    issue_tag,    0);
      check("rst_commit_valid", commit_valid, 0);
      check("rst_commit_rd",    commit_rd,    0);
      check("rst_flush",        flush,        0);
      check("rst_flush_pc",     flush_pc,     0);
      check("rst_train_valid",  train_valid,  0);
      check("rst_qj_rdy",       qj_rdy,       0);

      // ---------------- table: single-instruction lifecycles ----------------
      exp_tag = '0;
      for (int i = 0; i < 8; i++) begin
         issue_valid = 1'b1;
         issue_type  = vecs[i].typ;
         issue_rd    = vecs[i].rd;
         issue_pc    = vecs[i].pc;
         issue_pred  = vecs[i].pred;
         #1;
         check("v_issue_ready", issue_ready, 1);
         check("v_issue_tag",   issue_tag,   exp_tag);
         step();
         issue_valid = 1'b0;
         if (vecs[i].use_lsb) begin
            lsb_wb_valid = 1'b1;
            lsb_wb_tag   = exp_tag;
            lsb_wb_val   = vecs[i].val;
         end else begin
            alu_wb(exp_tag, vecs[i].val, vecs[i].taken, vecs[i].target);
         end
         step();
         alu_wb_valid = 1'b0;
         lsb_wb_valid = 1'b0;
         check("v_commit_not_yet", commit_valid, 0);
         step();
         check("v_commit_valid", commit_valid, 1);
         check("v_commit_tag",   commit_tag,   exp_tag);
         check("v_commit_rd",    commit_rd,    vecs[i].e_rd);
         check("v_commit_store", commit_store, vecs[i].e_store);
         check("v_flush",        flush,        vecs[i].e_flush);
         check("v_train_valid",  train_valid,  vecs[i].e_train);
         check("v_issue_ready_in_flush", issue_ready, !vecs[i].e_flush);
         if (vecs[i].chk_val) check("v_commit_val", commit_val, vecs[i].e_val);
         if (vecs[i].e_flush) check("v_flush_pc", flush_pc, vecs[i].e_flush_pc);
         if (vecs[i].e_train) begin
            check("v_train_taken", train_taken, vecs[i].e_train_taken);
            check("v_train_pc",    train_pc,    vecs[i].pc);
         end
         exp_tag = vecs[i].e_flush ? '0 : exp_tag + 1'b1;
         step();
         check("v_pulse_clear", commit_valid, 0);
         check("v_flush_clear", flush,        0);
         check("v_ready_after", issue_ready,  1);
         check("v_tag_after",   issue_tag,    exp_tag);
      end

      // ---------------- fill to 16, 17th refused ----------------
      do_reset();
      for (int i = 0; i < 16; i++) begin
         issue_valid = 1'b1;
         issue_type  = ROB_T_REG;
         issue_rd    = 5'(i + 1);
         issue_pc    = 32'(i * 4);
         #1;
         check("fill_ready", issue_ready, 1);
         check("fill_tag",   issue_tag,   i);
         step();
      end
      check("full_ready", issue_ready, 0);
      qj_tag = 4'd5;
      #1;
      check("busy_not_ready_rdy", qj_rdy, 0);
      check("busy_not_ready_val", qj_val, 0);
      step();
      check("full_17th_ready", issue_ready, 0);
      check("full_17th_tag",   issue_tag,   0);
      issue_valid = 1'b0;

      // ---------------- out-of-order writeback, in-order commit ----------------
      do_reset();
      for (int i = 0; i < 3; i++) begin
         issue_valid = 1'b1;
         issue_type  = ROB_T_REG;
         issue_rd    = 5'(10 + i);
         step();
      end
      issue_valid = 1'b0;
      alu_wb(4'd2, 32'h11, 1'b0, 32'h0);
      step();
      alu_wb(4'd1, 32'h22, 1'b0, 32'h0);
      qj_tag = 4'd2;
      #1;
      check("lookup_stored_rdy", qj_rdy, 1);
      check("lookup_stored_val", qj_val, 32'h11);
      step();
      alu_wb(4'd0, 32'h33, 1'b0, 32'h0);
      step();
      alu_wb_valid = 1'b0;
      check("ooo_no_commit_yet", commit_valid, 0);
      step();
      check("ooo_c0_valid", commit_valid, 1);
      check("ooo_c0_tag",   commit_tag,   0);
      check("ooo_c0_val",   commit_val,   32'h33);
      check("ooo_c0_rd",    commit_rd,    10);
      step();
      check("ooo_c1_valid", commit_valid, 1);
      check("ooo_c1_tag",   commit_tag,   1);
      check("ooo_c1_val",   commit_val,   32'h22);
      step();
      check("ooo_c2_valid", commit_valid, 1);
      check("ooo_c2_tag",   commit_tag,   2);
      check("ooo_c2_val",   commit_val,   32'h11);
      step();
      check("ooo_done", commit_valid, 0);

      // ---------------- wrap: head 14, tail 15, issue+commit together ----------------
      do_reset();
      for (int i = 0; i < 15; i++) begin
         issue_valid = 1'b1;
         issue_type  = ROB_T_REG;
         issue_rd    = 5'd4;
         step();
      end
      issue_valid = 1'b0;
      for (int t = 0; t < 14; t++) begin
         alu_wb(4'(t), 32'(t), 1'b0, 32'h0);
         step();
      end
      alu_wb_valid = 1'b0;
      step();
      step();
      alu_wb(4'd14, 32'h77, 1'b0, 32'h0);
      step();
      alu_wb_valid = 1'b0;
      issue_valid  = 1'b1;
      issue_type   = ROB_T_ST;
      issue_rd     = 5'd3;
      issue_pc     = 32'h500;
      #1;
      check("wrap_tag15",   issue_tag,   15);
      check("wrap_ready15", issue_ready, 1);
      step();
      issue_valid = 1'b0;
      #1;
      check("wrap_commit14_valid", commit_valid, 1);
      check("wrap_commit14_tag",   commit_tag,   14);
      check("wrap_commit14_val",   commit_val,   32'h77);
      check("wrap_tail0",          issue_tag,    0);
      lsb_wb_valid = 1'b1;
      lsb_wb_tag   = 4'd15;
      lsb_wb_val   = 32'h88;
      step();
      lsb_wb_valid = 1'b0;
      step();
      check("st_commit_valid", commit_valid, 1);
      check("st_commit_store", commit_store, 1);
      check("st_commit_tag",   commit_tag,   15);
      check("st_commit_rd",    commit_rd,    0);
      step();
      // count must be back to zero: exactly 16 more fit
      for (int i = 0; i < 16; i++) begin
         issue_valid = 1'b1;
         issue_type  = ROB_T_REG;
         #1;
         check("refill_ready", issue_ready, 1);
         step();
      end
      issue_valid = 1'b0;
      check("refill_full", issue_ready, 0);

      // ---------------- lookup vs same-cycle writeback ----------------
      do_reset();
      for (int i = 0; i < 4; i++) begin
         issue_valid = 1'b1;
         issue_type  = ROB_T_REG;
         step();
      end
      issue_valid = 1'b0;
      alu_wb(4'd3, 32'hABCD, 1'b0, 32'h0);
      qj_tag = 4'd3;
      qk_tag = 4'd2;
      #1;
`ifdef ROB_WB_BYPASS_EN
      check("bypass_same_rdy", qj_rdy, 1);
      check("bypass_same_val", qj_val, 32'hABCD);
`else
      check("nobypass_same_rdy", qj_rdy, 0);
      check("nobypass_same_val", qj_val, 0);
`endif
      check("pending_qk_rdy", qk_rdy, 0);
      step();
      alu_wb_valid = 1'b0;
      qk_tag = 4'd9;
      #1;
      check("lookup_next_rdy", qj_rdy, 1);
      check("lookup_next_val", qj_val, 32'hABCD);
      check("nonbusy_rdy",     qk_rdy, 0);
      check("nonbusy_val",     qk_val, 0);
      // rdy low: issue is held off
      rdy         = 1'b0;
      issue_valid = 1'b1;
      step();
      check("rdy_low_hold_tag", issue_tag, 4);
      rdy         = 1'b1;
      issue_valid = 1'b0;

      // ---------------- rst overrides a pending commit ----------------
      do_reset();
      issue_valid = 1'b1;
      issue_type  = ROB_T_REG;
      issue_rd    = 5'd9;
      step();
      issue_valid = 1'b0;
      alu_wb(4'd0, 32'h5A5A, 1'b0, 32'h0);
      step();
      alu_wb_valid = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      check("rst_mid_commit_valid", commit_valid, 0);
      check("rst_mid_commit_val",   commit_val,   0);
      check("rst_mid_tag",          issue_tag,    0);
      step();
      check("rst_mid_no_commit",    commit_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
